cache_control: RTL and testbench

Sequencing FSM for the 2-way, 8-set, 32-byte-line write-back cache datapath. It sits between the CPU-side memory interface, the physical-memory (pmem) interface and the cache datapath. It evaluates hit/miss and drives the datapath load strobes, way select, per-way byte write enables and mux selects. It also runs the write-back and line-fill handshakes and maintains the per-set LRU bit.

---
 rtl/cache_control_if.sv | 61 ++++++
 rtl/cache_control.sv | 219 +++++++++++++++++++++
 tb/tb_cache_control.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_control_if.sv
// cache_control_if
//   Bundles every signal between the cache controller and its surroundings:
//   the CPU request/response pair, the pmem line-fill/write-back handshake,
//   the status read out of the datapath arrays, and the array load strobes,
//   byte write enables and mux selects the controller drives.
//   master: the controller side (drives mem_resp, pmem_read/write, strobes).
//   slave : the environment side (CPU, pmem and datapath).
//   Parameter s_mask: bytes per cache line (width of the byte-enable vectors).
interface cache_control_if #(
  parameter int s_mask = 32
);
  // CPU side
  logic              mem_read;
  logic              mem_write;
  logic [s_mask-1:0] mem_byte_enable;
  logic              mem_resp;
  // pmem side
  logic              pmem_read;
  logic              pmem_write;
  logic              pmem_resp;
  // datapath status of the indexed set
  logic              hit0;
  logic              hit1;
  logic              V0;
  logic              V1;
  logic              D0;
  logic              D1;
  logic              lru_out;
  // datapath controls
  logic              ldLRU;
  logic              lru_in;
  logic              ldTag0;
  logic              ldTag1;
  logic              ldV0;
  logic              ldV1;
  logic              ldD0;
  logic              ldD1;
  logic              valid_in;
  logic              dirty_in;
  logic              way;
  logic [s_mask-1:0] wen0;
  logic [s_mask-1:0] wen1;
  logic              datain_sel;
  logic              pmem_addr_sel;

  modport master (
    input  mem_read, mem_write, mem_byte_enable, pmem_resp,
           hit0, hit1, V0, V1, D0, D1, lru_out,
    output mem_resp, pmem_read, pmem_write,
           ldLRU, lru_in, ldTag0, ldTag1, ldV0, ldV1, ldD0, ldD1,
           valid_in, dirty_in, way, wen0, wen1, datain_sel, pmem_addr_sel
  );

  modport slave (
    output mem_read, mem_write, mem_byte_enable, pmem_resp,
           hit0, hit1, V0, V1, D0, D1, lru_out,
    input  mem_resp, pmem_read, pmem_write,
           ldLRU, lru_in, ldTag0, ldTag1, ldV0, ldV1, ldD0, ldD1,
           valid_in, dirty_in, way, wen0, wen1, datain_sel, pmem_addr_sel
  );
endinterface

// File: rtl/cache_control.sv
// cache_control
//   Sequencing FSM for a 2-way, 8-set, write-back cache datapath.
//   IDLE presents the request address to the arrays, CHECK evaluates hit/miss
//   (completing hits and updating LRU/dirty), WB writes a dirty victim back to
//   pmem, FILL brings the requested line in and loads tag/valid/dirty, then
//   the access is re-checked and completes through the normal hit path.
//   Ports:
//     clk : rising-edge clock
//     rst : asynchronous active-high reset (state -> IDLE, victim -> 0)
//     bus : cache_control_if master modport (CPU, pmem and datapath signals)
//   All bus outputs are combinational from the state, victim and inputs.
module cache_control #(
  parameter int s_mask = 32
) (
  input  logic            clk,
  input  logic            rst,
  cache_control_if.master bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CHECK = 2'd1;
  localparam logic [1:0] WB    = 2'd2;
  localparam logic [1:0] FILL  = 2'd3;

  localparam logic [s_mask-1:0] full_line = {s_mask{1'b1}};

  logic [1:0]        state;
  logic [1:0]        next_state;
  logic              victim;
  logic              next_victim;

  logic              req;
  logic              is_write;
  logic              hit;
  logic              hit_way;
  logic              victim_dirty;

  logic              resp;
  logic              pmem_rd;
  logic              pmem_wr;
  logic              ld_lru;
  logic              lru_val;
  logic              ld_tag0;
  logic              ld_tag1;
  logic              ld_v0;
  logic              ld_v1;
  logic              ld_d0;
  logic              ld_d1;
  logic              valid_val;
  logic              dirty_val;
  logic              way_sel;
  logic [s_mask-1:0] wen_0;
  logic [s_mask-1:0] wen_1;
  logic              data_sel;
  logic              addr_sel;

  // A simultaneous read and write is treated as a write.
  assign req          = bus.mem_read | bus.mem_write;
  assign is_write     = bus.mem_write;
  assign hit          = bus.hit0 | bus.hit1;
  assign hit_way      = bus.hit1;
  // The LRU way is the eviction candidate; it needs write-back only if valid and dirty.
  assign victim_dirty = bus.lru_out ? (bus.V1 & bus.D1) : (bus.V0 & bus.D0);

  // State and victim registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      victim <= 1'b0;
    end else begin
      state  <= next_state;
      victim <= next_victim;
    end
  end

  // Next-state and victim-latch logic.
  always_comb begin
    next_state  = state;
    next_victim = victim;
    case (state)
      IDLE: begin
        if (req) begin
          next_state = CHECK;
        end else begin
          next_state = IDLE;
        end
      end
      CHECK: begin
        // A request dropped during a miss lands here with req low: just go idle.
        if (!req) begin
          next_state = IDLE;
        end else if (hit) begin
          next_state = IDLE;
        end else begin
          next_victim = bus.lru_out;
          next_state  = victim_dirty ? WB : FILL;
        end
      end
      WB: begin
        if (bus.pmem_resp) begin
          next_state = FILL;
        end else begin
          next_state = WB;
        end
      end
      FILL: begin
        if (bus.pmem_resp) begin
          next_state = CHECK;
        end else begin
          next_state = FILL;
        end
      end
      default: begin
        next_state  = IDLE;
        next_victim = 1'b0;
      end
    endcase
  end

  // Datapath strobes, mux selects and handshake outputs.
  always_comb begin
    resp      = 1'b0;
    pmem_rd   = 1'b0;
    pmem_wr   = 1'b0;
    ld_lru    = 1'b0;
    lru_val   = 1'b0;
    ld_tag0   = 1'b0;
    ld_tag1   = 1'b0;
    ld_v0     = 1'b0;
    ld_v1     = 1'b0;
    ld_d0     = 1'b0;
    ld_d1     = 1'b0;
    valid_val = 1'b0;
    dirty_val = 1'b0;
    way_sel   = 1'b0;
    wen_0     = {s_mask{1'b0}};
    wen_1     = {s_mask{1'b0}};
    data_sel  = 1'b0;
    addr_sel  = 1'b0;
    case (state)
      IDLE: begin
        resp = 1'b0;
      end
      CHECK: begin
        if (req && hit) begin
          way_sel = hit_way;
          ld_lru  = 1'b1;
          lru_val = ~hit_way;  // the way not just used becomes LRU
          resp    = 1'b1;
          if (is_write) begin
            dirty_val = 1'b1;
            if (hit_way) begin
              wen_1 = bus.mem_byte_enable;
              ld_d1 = 1'b1;
            end else begin
              wen_0 = bus.mem_byte_enable;
              ld_d0 = 1'b1;
            end
          end else begin
            dirty_val = 1'b0;
          end
        end else begin
          // miss or dropped request: no array writes, no response
          resp = 1'b0;
        end
      end
      WB: begin
        pmem_wr  = 1'b1;
        addr_sel = 1'b1;
        way_sel  = victim;
      end
      FILL: begin
        pmem_rd = 1'b1;
        way_sel = victim;
        if (bus.pmem_resp) begin
          data_sel  = 1'b1;
          valid_val = 1'b1;
          dirty_val = 1'b0;
          if (victim) begin
            wen_1   = full_line;
            ld_tag1 = 1'b1;
            ld_v1   = 1'b1;
            ld_d1   = 1'b1;
          end else begin
            wen_0   = full_line;
            ld_tag0 = 1'b1;
            ld_v0   = 1'b1;
            ld_d0   = 1'b1;
          end
        end else begin
          data_sel = 1'b0;
        end
      end
      default: begin
        resp = 1'b0;
      end
    endcase
  end

  assign bus.mem_resp      = resp;
  assign bus.pmem_read     = pmem_rd;
  assign bus.pmem_write    = pmem_wr;
  assign bus.ldLRU         = ld_lru;
  assign bus.lru_in        = lru_val;
  assign bus.ldTag0        = ld_tag0;
  assign bus.ldTag1        = ld_tag1;
  assign bus.ldV0          = ld_v0;
  assign bus.ldV1          = ld_v1;
  assign bus.ldD0          = ld_d0;
  assign bus.ldD1          = ld_d1;
  assign bus.valid_in      = valid_val;
  assign bus.dirty_in      = dirty_val;
  assign bus.way           = way_sel;
  assign bus.wen0          = wen_0;
  assign bus.wen1          = wen_1;
  assign bus.datain_sel    = data_sel;
  assign bus.pmem_addr_sel = addr_sel;

endmodule

// File: tb/tb_cache_control.sv
// tb_cache_control
//   Drives CPU requests and pmem responses, plays the datapath arrays from a
//   transaction-level cache model (tags, valid, dirty, LRU per set/way), and
//   compares every controller output against the cycle sequence the cache
//   protocol prescribes for each access (hit, clean miss, dirty miss).
module tb_cache_control;

  localparam int SM = 32;

  typedef struct packed {
    logic        mem_resp;
    logic        pmem_read;
    logic        pmem_write;
    logic        ldLRU;
    logic        lru_in;
    logic        ldTag0;
    logic        ldTag1;
    logic        ldV0;
    logic        ldV1;
    logic        ldD0;
    logic        ldD1;
    logic        valid_in;
    logic        dirty_in;
    logic        way;
    logic [31:0] wen0;
    logic [31:0] wen1;
    logic        datain_sel;
    logic        pmem_addr_sel;
  } outs_t;

  logic clk = 1'b0;
  logic rst;

  cache_control_if #(.s_mask(SM)) bus ();

  cache_control #(.s_mask(SM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  outs_t act;
  always_comb begin
    act               = '0;
    act.mem_resp      = bus.mem_resp;
    act.pmem_read     = bus.pmem_read;
    act.pmem_write    = bus.pmem_write;
    act.ldLRU         = bus.ldLRU;
    act.lru_in        = bus.lru_in;
    act.ldTag0        = bus.ldTag0;
    act.ldTag1        = bus.ldTag1;
    act.ldV0          = bus.ldV0;
    act.ldV1          = bus.ldV1;
    act.ldD0          = bus.ldD0;
    act.ldD1          = bus.ldD1;
    act.valid_in      = bus.valid_in;
    act.dirty_in      = bus.dirty_in;
    act.way           = bus.way;
    act.wen0          = bus.wen0;
    act.wen1          = bus.wen1;
    act.datain_sel    = bus.datain_sel;
    act.pmem_addr_sel = bus.pmem_addr_sel;
  end

  // cache model: what the datapath arrays hold
  logic [23:0] mtag [8][2];
  logic        mv   [8][2];
  logic        md   [8][2];
  logic        mlru [8];

  logic [23:0] ct;
  logic [2:0]  cs;

  int    n_chk  = 0;
  int    n_fail = 0;
  string phase;

  logic        last_way;
  logic        last_lru_in;
  logic [31:0] last_wen0;
  logic [31:0] last_wen1;

  // present the indexed set's status for the current request
  task automatic drive_dp();
    bus.hit0    = mv[cs][0] && (mtag[cs][0] == ct);
    bus.hit1    = mv[cs][1] && (mtag[cs][1] == ct);
    bus.V0      = mv[cs][0];
    bus.V1      = mv[cs][1];
    bus.D0      = md[cs][0];
    bus.D1      = md[cs][1];
    bus.lru_out = mlru[cs];
  endtask

  // one clock cycle: compare outputs mid-cycle, then advance past the edge
  task automatic step(input outs_t e);
    @(negedge clk);
    n_chk++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", phase, act, e);
    end
    if (act.mem_resp === 1'b1) begin
      last_way    = act.way;
      last_lru_in = act.lru_in;
      last_wen0   = act.wen0;
      last_wen1   = act.wen1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // one complete CPU access from request to completion (or drop)
  task automatic do_txn(input logic [23:0] t, input logic [2:0] s, input logic rd,
                        input logic wr, input logic [31:0] be, input int lwb,
                        input int lfill, input logic drop);
    outs_t e;
    logic  vic;
    logic  dirty;
    logic  hw;
    logic  live;
    ct = t;
    cs = s;
    bus.mem_read        = rd;
    bus.mem_write       = wr;
    bus.mem_byte_enable = be;
    bus.pmem_resp       = 1'($urandom_range(0, 1));  // ignored outside WB/FILL
    drive_dp();
    live  = 1'b1;
    phase = "idle_req";
    step('0);
    if (!(bus.hit0 || bus.hit1)) begin
      vic   = mlru[s];
      dirty = mv[s][vic] && md[s][vic];
      phase = "check_miss";
      step('0);
      if (dirty) begin
        for (int k = 0; k <= lwb; k++) begin
          bus.pmem_resp   = (k == lwb);
          e               = '0;
          e.pmem_write    = 1'b1;
          e.pmem_addr_sel = 1'b1;
          e.way           = vic;
          phase           = "wb";
          step(e);
        end
      end
      if (drop) begin
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        live          = 1'b0;
      end
      for (int k = 0; k <= lfill; k++) begin
        bus.pmem_resp = (k == lfill);
        e             = '0;
        e.pmem_read   = 1'b1;
        e.way         = vic;
        if (k == lfill) begin
          e.datain_sel = 1'b1;
          e.valid_in   = 1'b1;
          e.dirty_in   = 1'b0;
          if (vic) begin
            e.wen1 = 32'hFFFF_FFFF; e.ldTag1 = 1'b1; e.ldV1 = 1'b1; e.ldD1 = 1'b1;
          end else begin
            e.wen0 = 32'hFFFF_FFFF; e.ldTag0 = 1'b1; e.ldV0 = 1'b1; e.ldD0 = 1'b1;
          end
        end
        phase = "fill";
        step(e);
      end
      mtag[s][vic]  = t;
      mv[s][vic]    = 1'b1;
      md[s][vic]    = 1'b0;
      bus.pmem_resp = 1'b0;
      drive_dp();
    end
    if (live) begin
      hw         = bus.hit1;
      e          = '0;
      e.mem_resp = 1'b1;
      e.way      = hw;
      e.ldLRU    = 1'b1;
      e.lru_in   = ~hw;
      if (wr) begin
        e.dirty_in = 1'b1;
        if (hw) begin e.wen1 = be; e.ldD1 = 1'b1; end
        else    begin e.wen0 = be; e.ldD0 = 1'b1; end
      end
      phase = "check_hit";
      step(e);
      mlru[s] = ~hw;
      if (wr) md[s][hw] = 1'b1;
    end else begin
      phase = "check_dropped";
      step('0);
    end
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.pmem_resp = 1'b0;
    drive_dp();
  endtask

  initial begin
    outs_t e;
    for (int i = 0; i < 8; i++) begin
      mlru[i] = 1'b0;
      for (int j = 0; j < 2; j++) begin
        mtag[i][j] = 24'd0; mv[i][j] = 1'b0; md[i][j] = 1'b0;
      end
    end
    ct = 24'd0; cs = 3'd0;
    last_way = 1'b0; last_lru_in = 1'b0; last_wen0 = 32'd0; last_wen1 = 32'd0;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.mem_byte_enable = 32'd0;
    bus.pmem_resp = 1'b0;
    drive_dp();
    rst = 1'b1;
    @(posedge clk);
    #1;
    phase = "reset";
    step('0);
    rst = 1'b0;
    phase = "post_reset_idle";
    step('0);

    // cold read of 0x20: set 1, tag 0, everything invalid
    do_txn(24'h0, 3'd1, 1'b1, 1'b0, 32'd0, 0, 2, 1'b0);
    lit("cold_way", {31'd0, last_way}, 32'd0);
    lit("cold_lru_in", {31'd0, last_lru_in}, 32'd1);
    lit("cold_model_lru", {31'd0, mlru[1]}, 32'd1);
    // read hit
    do_txn(24'h0, 3'd1, 1'b1, 1'b0, 32'd0, 0, 0, 1'b0);
    lit("hit_way", {31'd0, last_way}, 32'd0);
    // write hit 0x24, byte enable 0xF0
    do_txn(24'h0, 3'd1, 1'b0, 1'b1, 32'h0000_00F0, 0, 0, 1'b0);
    lit("wr_wen0", last_wen0, 32'h0000_00F0);
    lit("wr_wen1", last_wen1, 32'd0);
    // fill way 1 with tag 1
    do_txn(24'h1, 3'd1, 1'b1, 1'b0, 32'd0, 0, 1, 1'b0);
    lit("way1_fill_way", {31'd0, last_way}, 32'd1);
    // tag 2 evicts dirty way 0
    lit("evict_victim", {31'd0, mlru[1]}, 32'd0);
    lit("evict_dirty", {31'd0, md[1][0]}, 32'd1);
    do_txn(24'h2, 3'd1, 1'b1, 1'b0, 32'd0, 2, 1, 1'b0);
    lit("evict_way", {31'd0, last_way}, 32'd0);
    lit("evict_clean_after", {31'd0, md[1][0]}, 32'd0);
    // read and write together on a hit behave as a write
    do_txn(24'h2, 3'd1, 1'b1, 1'b1, 32'h0F0F_0000, 0, 0, 1'b0);
    lit("both_wen0", last_wen0, 32'h0F0F_0000);
    // make way 1 dirty too, then a miss to tag 3 must write way 0 back
    do_txn(24'h1, 3'd1, 1'b0, 1'b1, 32'h0000_0001, 0, 0, 1'b0);

    // reset in the middle of a write-back
    ct = 24'h3; cs = 3'd1;
    bus.mem_read = 1'b1;
    drive_dp();
    phase = "rst_idle_req";
    step('0);
    phase = "rst_check_miss";
    step('0);
    e = '0; e.pmem_write = 1'b1; e.pmem_addr_sel = 1'b1; e.way = 1'b0;
    phase = "rst_wb";
    step(e);
    rst = 1'b1;
    phase = "rst_during_wb";
    step('0);
    rst = 1'b0;
    bus.mem_read = 1'b0;
    bus.pmem_resp = 1'b1;
    phase = "stray_resp_idle";
    step('0);
    bus.pmem_resp = 1'b0;
    phase = "idle_after_stray";
    step('0);
    // the same access now completes normally from scratch
    do_txn(24'h3, 3'd1, 1'b1, 1'b0, 32'd0, 1, 0, 1'b0);

    // randomized traffic
    for (int n = 0; n < 200; n++) begin
      int    kind;
      int    gap;
      kind = $urandom_range(0, 2);
      do_txn(24'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
             (kind != 1), (kind != 0), $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3),
             ($urandom_range(0, 9) == 0));
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        bus.pmem_resp = 1'($urandom_range(0, 1));
        phase = "gap_idle";
        step('0);
      end
      bus.pmem_resp = 1'b0;
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
